// File: rtl/gmii_tx_ctrl.sv
// GMII transmit framer: preamble, SFD, payload, zero pad, Ethernet FCS, inter-frame gap.
// Includes the byte-wide CRC-32 engine that computes the FCS on the fly.

module gmii_crc32_d8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        crc_en_i,
  input  logic        crc_rst_i,
  input  logic [7:0]  data_in_i,
  output logic [31:0] crc_out_o
);

  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // MSB-first LFSR; the caller bit-reverses bytes to get Ethernet's LSB-first order.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (crc_rst_i) begin
      crc_d = '1;
    end else if (crc_en_i) begin
      crc_d = crc_step(crc_q, data_in_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '1;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out_o = crc_q;

endmodule

module gmii_tx_ctrl #(
  parameter int IFG_CYCLES  = 12,
  parameter int MIN_PAYLOAD = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_start,
  input  logic [10:0] tx_len,
  input  logic [7:0]  data_in,
  output logic        data_rd,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        tx_busy,
  output logic        tx_done
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_PAYLOAD);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(6);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS,
    S_IFG
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [10:0]      len_q, len_d;
  logic [7:0]       txd_q, txd_d;
  logic             en_q, en_d;
  logic [31:0]      fcs_q, fcs_d;

  logic             crc_en;
  logic             crc_rst;
  logic [7:0]       crc_din;
  logic [31:0]      crc_out;
  logic [31:0]      fcs_now;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] len_ext;

  assign cnt_inc = cnt_q + 1'b1;
  assign len_ext = {{(CNT_W-11){1'b0}}, len_q};

  // The CRC sees the byte being loaded, bit-reversed; FCS is the reflected, inverted register.
  for (genvar gi = 0; gi < 8; gi++) begin : g_din_rev
    assign crc_din[gi] = txd_d[7-gi];
  end
  for (genvar gi = 0; gi < 32; gi++) begin : g_fcs_rev
    assign fcs_now[gi] = ~crc_out[31-gi];
  end

  gmii_crc32_d8 u_crc (
    .clk       (clk),
    .rst_n     (rst_n),
    .crc_en_i  (crc_en),
    .crc_rst_i (crc_rst),
    .data_in_i (crc_din),
    .crc_out_o (crc_out)
  );

  // State names the phase of the byte being loaded into gmii_txd in this cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    txd_d   = 8'h00;
    en_d    = 1'b0;
    fcs_d   = fcs_q;
    crc_en  = 1'b0;
    crc_rst = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          len_d   = tx_len;
          txd_d   = 8'h55;
          en_d    = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        txd_d = 8'h55;
        en_d  = 1'b1;
        cnt_d = cnt_inc;
        if (cnt_q == PRE_LAST) begin
          state_d = S_SFD;
        end
      end
      S_SFD: begin
        txd_d   = 8'hD5;
        en_d    = 1'b1;
        crc_rst = 1'b1;
        cnt_d   = '0;
        if (len_q != 11'd0) begin
          state_d = S_DATA;
        end else if (MIN_W != '0) begin
          state_d = S_PAD;
        end else begin
          state_d = S_FCS;
        end
      end
      S_DATA: begin
        txd_d  = data_in;
        en_d   = 1'b1;
        crc_en = 1'b1;
        cnt_d  = cnt_inc;
        if (cnt_inc == len_ext) begin
          if (len_ext < MIN_W) begin
            state_d = S_PAD;
          end else begin
            state_d = S_FCS;
            cnt_d   = '0;
          end
        end
      end
      S_PAD: begin
        en_d   = 1'b1;
        crc_en = 1'b1;
        cnt_d  = cnt_inc;
        if (cnt_inc == MIN_W) begin
          state_d = S_FCS;
          cnt_d   = '0;
        end
      end
      S_FCS: begin
        en_d  = 1'b1;
        cnt_d = cnt_inc;
        case (cnt_q[1:0])
          2'd0: begin
            fcs_d = fcs_now;
            txd_d = fcs_now[7:0];
          end
          2'd1: txd_d = fcs_q[15:8];
          2'd2: txd_d = fcs_q[23:16];
          default: begin
            txd_d   = fcs_q[31:24];
            state_d = S_IFG;
            cnt_d   = '0;
          end
        endcase
      end
      S_IFG: begin
        cnt_d = cnt_inc;
        if (cnt_q == IFG_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      txd_q   <= 8'h00;
      en_q    <= 1'b0;
      fcs_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      txd_q   <= txd_d;
      en_q    <= en_d;
      fcs_q   <= fcs_d;
    end
  end

  assign gmii_txd   = txd_q;
  assign gmii_tx_en = en_q;
  assign data_rd    = (state_q == S_DATA);
  assign tx_busy    = (state_q != S_IDLE);
  assign tx_done    = (state_q == S_IFG) && (cnt_q == IFG_LAST);

endmodule

// File: tb/tb_gmii_tx_ctrl.sv
// Randomised bench for gmii_tx_ctrl: two instances (default pad and no pad) against a frame model.
// The model builds each expected frame as a byte queue and computes FCS with a reflected CRC-32.

module tb_gmii_tx_ctrl;

  localparam int IFG  = 12;
  localparam int MINP = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_start = 1'b0;
  logic [10:0] tx_len = '0;
  logic [7:0]  data_in = '0;
  bit          sel = 1'b0;

  logic        rd_a, en_a, busy_a, done_a, rd_b, en_b, busy_b, done_b;
  logic [7:0]  txd_a, txd_b;
  logic        o_rd, o_en, o_busy, o_done;
  logic [7:0]  o_txd;

  always #5 clk = ~clk;

  gmii_tx_ctrl #(.IFG_CYCLES(IFG), .MIN_PAYLOAD(MINP)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start & ~sel), .tx_len(tx_len), .data_in(data_in),
    .data_rd(rd_a), .gmii_txd(txd_a), .gmii_tx_en(en_a), .tx_busy(busy_a), .tx_done(done_a)
  );

  gmii_tx_ctrl #(.IFG_CYCLES(IFG), .MIN_PAYLOAD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start & sel), .tx_len(tx_len), .data_in(data_in),
    .data_rd(rd_b), .gmii_txd(txd_b), .gmii_tx_en(en_b), .tx_busy(busy_b), .tx_done(done_b)
  );

  always_comb begin
    o_rd   = sel ? rd_b   : rd_a;
    o_en   = sel ? en_b   : en_a;
    o_busy = sel ? busy_b : busy_a;
    o_done = sel ? done_b : done_a;
    o_txd  = sel ? txd_b  : txd_a;
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] pay [0:2047];
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];
  int rd_cnt, en_cyc, en_runs, done_cnt, last_en_cyc, done_cyc, first_en_cyc, busy_low;
  bit timed_out;

  function automatic void fill_payload(input int len);
    for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
  endfunction

  // Expected on-wire frame: preamble, SFD, payload, zero pad, FCS LSB first.
  function automatic void build_expected(input int len, input int minp);
    logic [31:0] c;
    int tot;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    tot = (len > minp) ? len : minp;
    for (int i = 0; i < tot; i++) exp_q.push_back((i < len) ? pay[i] : 8'h00);
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < exp_q.size(); i++) begin
      c = c ^ {24'h0, exp_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[23:16]);
    exp_q.push_back(c[31:24]);
  endfunction

  // -1 when captured frame equals the expected one, -2 on length difference, else first bad index.
  function automatic int first_diff();
    if (cap_q.size() != exp_q.size()) return -2;
    for (int i = 0; i < cap_q.size(); i++) if (cap_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // Starts one frame and follows it until tx_done; optionally pulses tx_start again at pulse_cyc.
  task automatic drive_frame(input int len, input int pulse_cyc, input int pulse_len);
    int k;
    bit prev_en;
    cap_q.delete();
    rd_cnt = 0; en_cyc = 0; en_runs = 0; done_cnt = 0; busy_low = 0;
    last_en_cyc = -1; done_cyc = -1; first_en_cyc = -1; timed_out = 1'b1;
    k = 0; prev_en = 1'b0;
    @(negedge clk);
    tx_start = 1'b1;
    tx_len   = 11'(len);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      tx_start = (cyc == pulse_cyc);
      if (cyc == pulse_cyc) tx_len = 11'(pulse_len);
      if (o_en) begin
        cap_q.push_back(o_txd);
        if (!prev_en) en_runs++;
        if (en_cyc == 0) first_en_cyc = cyc;
        en_cyc++;
        last_en_cyc = cyc;
      end
      prev_en = o_en;
      if (o_rd) begin
        data_in = pay[k];
        if (k < 2047) k++;
        rd_cnt++;
      end
      if (!o_busy) busy_low++;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        timed_out = 1'b0;
        break;
      end
    end
    tx_start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++; if (o_en !== 1'b0) begin errors++; $display("FAIL reset_en dut%0d: got %b want 0", s, o_en); end
      checks++; if (o_txd !== 8'h00) begin errors++; $display("FAIL reset_txd dut%0d: got %h want 00", s, o_txd); end
      checks++; if (o_rd !== 1'b0) begin errors++; $display("FAIL reset_rd dut%0d: got %b want 0", s, o_rd); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b want 0", s, o_busy); end
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done dut%0d: got %b want 0", s, o_done); end
    end
    checks++;
    if (dut_a.u_crc.crc_q !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL reset_crc: got %h want ffffffff", dut_a.u_crc.crc_q);
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_check_value;
    int d;
    sel = 1'b1;
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    build_expected(9, 0);
    drive_frame(9, -1, 0);
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL check_bytes: first bad index %0d (got %0d bytes, want %0d)", d, cap_q.size(), exp_q.size()); end
    checks++;
    if (cap_q.size() != 21 || {cap_q[17], cap_q[18], cap_q[19], cap_q[20]} !== 32'h2639_F4CB) begin
      errors++; $display("FAIL check_fcs: got %0d bytes, tail %h want 2639f4cb", cap_q.size(),
                        (cap_q.size() == 21) ? {cap_q[17], cap_q[18], cap_q[19], cap_q[20]} : 32'h0);
    end
    checks++; if (en_cyc != 21) begin errors++; $display("FAIL check_en_len: got %0d want 21", en_cyc); end
    checks++; if (first_en_cyc != 0) begin errors++; $display("FAIL check_latency: got %0d want 0", first_en_cyc); end
    checks++; if (rd_cnt != 9) begin errors++; $display("FAIL check_rd: got %0d want 9", rd_cnt); end
    sel = 1'b0;
    $display("test_check_value: len=9 en=%0d rd=%0d", en_cyc, rd_cnt);
  endtask

  task automatic test_frames(input int len, input bit use_b);
    int d, minp, want_en;
    sel = use_b;
    minp = use_b ? 0 : MINP;
    want_en = 8 + ((len > minp) ? len : minp) + 4;
    fill_payload(len);
    build_expected(len, minp);
    drive_frame(len, -1, 0);
    d = first_diff();
    checks++; if (timed_out) begin errors++; $display("FAIL frame_timeout len=%0d: no tx_done within budget", len); end
    checks++; if (d != -1) begin errors++; $display("FAIL frame_bytes len=%0d: first bad index %0d (got %0d want %0d bytes)", len, d, cap_q.size(), exp_q.size()); end
    checks++; if (en_cyc != want_en || en_runs != 1) begin errors++; $display("FAIL frame_en len=%0d: got %0d cycles in %0d runs want %0d in 1", len, en_cyc, en_runs, want_en); end
    checks++; if (rd_cnt != len) begin errors++; $display("FAIL frame_rd len=%0d: got %0d want %0d", len, rd_cnt, len); end
    checks++; if (busy_low != 0) begin errors++; $display("FAIL frame_busy len=%0d: busy low %0d cycles want 0", len, busy_low); end
    // tx_done marks the last gap-state cycle; the gap's final idle output cycle follows it.
    checks++; if (done_cyc - last_en_cyc != IFG - 1) begin errors++; $display("FAIL frame_done_pos len=%0d: got %0d want %0d", len, done_cyc - last_en_cyc, IFG - 1); end
    sel = 1'b0;
    $display("frame dut%0d len=%0d en=%0d rd=%0d", use_b, len, en_cyc, rd_cnt);
  endtask

  task automatic test_back_to_back;
    int gaps[$];
    int runs, ended, idle, k, dones, cur_len, bad_bytes, bad_len, rds;
    bit prev_en;
    logic [7:0] fr[$];
    sel = 1'b0;
    fill_payload(64);
    build_expected(64, MINP);
    runs = 0; ended = 0; idle = 0; k = 0; dones = 0; cur_len = 0; bad_bytes = 0; bad_len = 0; rds = 0;
    prev_en = 1'b0;
    @(negedge clk);
    tx_start = 1'b1;
    tx_len   = 11'd64;
    for (int cyc = 0; cyc < 2000 && dones < 3; cyc++) begin
      @(negedge clk);
      if (o_en && !prev_en) begin
        runs++;
        if (runs > 1) gaps.push_back(idle);
        fr.delete(); k = 0; cur_len = 0; rds = 0;
      end
      if (o_en) begin fr.push_back(o_txd); cur_len++; idle = 0; end
      else idle++;
      if (!o_en && prev_en) begin
        ended++;
        if (cur_len != 76 || rds != 64) bad_len++;
        for (int i = 0; i < fr.size() && i < exp_q.size(); i++) if (fr[i] !== exp_q[i]) bad_bytes++;
        if (ended == 3) tx_start = 1'b0;
      end
      prev_en = o_en;
      if (o_rd) begin data_in = pay[k]; k = (k < 63) ? k + 1 : 63; rds++; end
      if (o_done) dones++;
    end
    tx_start = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (o_en) runs++;
      if (o_done) dones++;
    end
    checks++; if (runs != 3 || ended != 3) begin errors++; $display("FAIL b2b_frames: got %0d starts %0d ends want 3", runs, ended); end
    checks++; if (gaps.size() != 2 || gaps[0] != IFG || gaps[1] != IFG) begin
      errors++; $display("FAIL b2b_gap: got %0d gaps first %0d want 2 gaps of %0d", gaps.size(), (gaps.size() > 0) ? gaps[0] : -1, IFG);
    end
    checks++; if (dones != 3) begin errors++; $display("FAIL b2b_done: got %0d want 3", dones); end
    checks++; if (bad_len != 0 || bad_bytes != 0) begin errors++; $display("FAIL b2b_content: %0d bad frame lengths, %0d bad bytes want 0", bad_len, bad_bytes); end
    $display("test_back_to_back: frames=%0d dones=%0d", runs, dones);
  endtask

  task automatic test_reset_mid_frame;
    int k, seen_en, seen_done;
    bit ok;
    sel = 1'b0;
    fill_payload(100);
    cap_q.delete();
    k = 0; ok = 1'b0;
    @(negedge clk);
    tx_start = 1'b1;
    tx_len   = 11'd100;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      tx_start = 1'b0;
      if (o_en) cap_q.push_back(o_txd);
      if (o_rd) begin data_in = pay[k]; k++; end
      if (cap_q.size() == 38) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL midrst_reach: got %0d bytes want 38", cap_q.size()); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (o_en !== 1'b0) begin errors++; $display("FAIL midrst_async_en: got %b want 0", o_en); end
    checks++; if (o_txd !== 8'h00 || o_busy !== 1'b0 || o_rd !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: txd %h busy %b rd %b want 00 0 0", o_txd, o_busy, o_rd);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen_en = 0; seen_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_en) seen_en++;
      if (o_done) seen_done++;
    end
    checks++; if (seen_en != 0 || seen_done != 0) begin errors++; $display("FAIL midrst_quiet: en %0d done %0d want 0 0", seen_en, seen_done); end
    $display("test_reset_mid_frame: aborted at byte %0d", cap_q.size());
    test_frames(33, 1'b0);
  endtask

  task automatic test_ignore_start(input int pulse_cyc);
    int d, seen_en, seen_done;
    sel = 1'b0;
    fill_payload(20);
    build_expected(20, MINP);
    drive_frame(20, pulse_cyc, 5);
    d = first_diff();
    checks++; if (d != -1 || en_cyc != 72) begin errors++; $display("FAIL ignore_frame pulse@%0d: first bad %0d en %0d want -1 72", pulse_cyc, d, en_cyc); end
    checks++; if (rd_cnt != 20 || done_cnt != 1) begin errors++; $display("FAIL ignore_counts pulse@%0d: rd %0d done %0d want 20 1", pulse_cyc, rd_cnt, done_cnt); end
    seen_en = 0; seen_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_en) seen_en++;
      if (o_done) seen_done++;
    end
    checks++; if (seen_en != 0 || seen_done != 0) begin errors++; $display("FAIL ignore_queued pulse@%0d: en %0d done %0d want 0 0", pulse_cyc, seen_en, seen_done); end
    $display("test_ignore_start: pulse at cycle %0d", pulse_cyc);
  endtask

  initial begin
    test_reset();
    test_check_value();
    test_frames(10, 1'b0);
    test_frames(0, 1'b0);
    test_frames(59, 1'b0);
    test_frames(60, 1'b0);
    test_frames(61, 1'b0);
    for (int i = 0; i < 5; i++) test_frames($urandom_range(1, 130), 1'b0);
    test_frames(0, 1'b1);
    for (int i = 0; i < 3; i++) test_frames($urandom_range(1, 80), 1'b1);
    test_back_to_back();
    test_reset_mid_frame();
    test_ignore_start(30);
    test_ignore_start(76);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
